// File: rtl/flappy_pkg.sv
// Shared constants, FSM encoding and LFSR helper for the pipe table writer.
package flappy_pkg;

  localparam int unsigned CoordW  = 10;
  localparam int unsigned ScreenW = 640;
  localparam int unsigned ScreenH = 480;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 (right-shifting form)
  localparam logic [15:0] LfsrTaps = 16'hB400;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StCalc,
    StWrite
  } wr_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = cur[0] ? ((cur >> 1) ^ LfsrTaps) : (cur >> 1);
  endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// 16-bit Galois LFSR with step enable; async active-low reset loads the seed.
module pipe_lfsr
  import flappy_pkg::*;
#(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= Seed;
    end else if (step) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/pipe_table_writer.sv
// Scrolls NPIPE pipe entries per tick and streams them to the pipe RAM.
// Optional PIPE_SPEEDUP_EN: speed rises by one every 16 score pulses, up to 2*SPEED.
module pipe_table_writer
  import flappy_pkg::*;
#(
  parameter int unsigned NPIPE     = 4,
  parameter int unsigned SPACING   = 160,
  parameter int unsigned SPEED     = 2,
  parameter int unsigned GAP_MIN   = 64,
  parameter int unsigned BIRD_X    = 200,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int unsigned IdxW     = (NPIPE > 1) ? $clog2(NPIPE) : 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              tick,
  input  logic              freeze,
  output logic              busy,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [IdxW-1:0]   wr_idx,
  output logic [CoordW-1:0] wr_x,
  output logic [CoordW-1:0] wr_y,
  output logic              score_pulse,
  output logic              overrun
);

  localparam logic [IdxW-1:0]   LastIdx = IdxW'(NPIPE - 1);
  localparam logic [CoordW:0]   WrapX   = (CoordW + 1)'(NPIPE * SPACING);
  localparam logic [CoordW-1:0] BirdX   = CoordW'(BIRD_X);
  localparam logic [CoordW-1:0] GapMin  = CoordW'(GAP_MIN);

  wr_state_e         state_q;
  logic [IdxW-1:0]   idx_q;
  logic              init_q;
  logic [CoordW-1:0] x_q [NPIPE];
  logic [CoordW-1:0] y_q [NPIPE];

  logic [15:0]       lfsr;
  logic [CoordW-1:0] speed;
  logic [CoordW-1:0] cur_x, cur_y, nx, ny;
  logic [CoordW:0]   respawn_sum;
  logic              respawn, passes;

`ifdef PIPE_SPEEDUP_EN
  logic [3:0]        score_cnt_q;
  logic [CoordW-1:0] speed_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      score_cnt_q <= '0;
      speed_q     <= CoordW'(SPEED);
    end else if (score_pulse) begin
      score_cnt_q <= score_cnt_q + 4'd1;
      if (score_cnt_q == 4'hF && speed_q < CoordW'(2 * SPEED)) begin
        speed_q <= speed_q + 1'b1;
      end
    end
  end

  assign speed = speed_q;
`else
  assign speed = CoordW'(SPEED);
`endif

  always_comb begin
    cur_x       = x_q[idx_q];
    cur_y       = y_q[idx_q];
    respawn     = cur_x < speed;
    respawn_sum = {1'b0, cur_x} + WrapX - {1'b0, speed};
    nx          = respawn ? respawn_sum[CoordW-1:0] : cur_x - speed;
    ny          = respawn ? GapMin + {2'b00, lfsr[7:0]} : cur_y;
    // A respawned entry jumps right, so it can never count as passing the bird.
    passes      = !respawn && (cur_x >= BirdX) && (nx < BirdX);
  end

  pipe_lfsr #(
    .Seed (LFSR_SEED)
  ) u_lfsr (
    .clk   (Clk),
    .rst_n (Reset_n),
    .step  ((state_q == StCalc) && respawn),
    .state (lfsr)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= StInit;
      idx_q       <= '0;
      init_q      <= 1'b1;
      busy        <= 1'b1;
      wr_valid    <= 1'b0;
      wr_idx      <= '0;
      wr_x        <= '0;
      wr_y        <= '0;
      score_pulse <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < NPIPE; i++) begin
        x_q[i] <= CoordW'((i + 1) * SPACING);
        y_q[i] <= GapMin;
      end
    end else begin
      score_pulse <= 1'b0;
      if (tick && busy) begin
        overrun <= 1'b1;
      end
      unique case (state_q)
        StInit: begin
          wr_idx   <= idx_q;
          wr_x     <= cur_x;
          wr_y     <= cur_y;
          wr_valid <= 1'b1;
          state_q  <= StWrite;
        end
        StIdle: begin
          if (tick && !freeze) begin
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          x_q[idx_q]  <= nx;
          y_q[idx_q]  <= ny;
          wr_idx      <= idx_q;
          wr_x        <= nx;
          wr_y        <= ny;
          wr_valid    <= 1'b1;
          score_pulse <= passes;
          state_q     <= StWrite;
        end
        StWrite: begin
          if (wr_ready) begin
            wr_valid <= 1'b0;
            if (idx_q == LastIdx) begin
              busy    <= 1'b0;
              init_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= init_q ? StInit : StCalc;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_table_writer.sv
// Directed bench for pipe_table_writer: init pass, scrolling, scoring, respawn, stall, reset.
module tb_pipe_table_writer;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       tick = 1'b0;
  logic       freeze = 1'b0;
  logic       busy;
  logic       wr_valid;
  logic       wr_ready = 1'b1;
  logic [1:0] wr_idx;
  logic [9:0] wr_x;
  logic [9:0] wr_y;
  logic       score_pulse;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_total = 0;

  // Scroll model used for the bulk ticks between hand-checked passes.
  int          mx [4];
  int          my [4];
  logic [15:0] mlfsr = 16'hACE1;

  pipe_table_writer u_dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .tick        (tick),
    .freeze      (freeze),
    .busy        (busy),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_idx      (wr_idx),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .score_pulse (score_pulse),
    .overrun     (overrun)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (score_pulse) pulse_total++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_tick();
    @(negedge Clk) tick = 1'b1;
    @(negedge Clk) tick = 1'b0;
  endtask

  // Waits (bounded) for an accepted write, checks it, then steps past that cycle.
  task automatic wait_write(input int idx, input int ex, input int ey, input int ep,
                            output int lat);
    lat = 0;
    while (!(wr_valid && wr_ready) && lat < 50) begin
      @(negedge Clk);
      lat++;
    end
    check_eq("write_seen", 32'(wr_valid && wr_ready), 32'd1);
    check_eq("wr_idx", 32'(wr_idx), 32'(idx));
    check_eq("wr_x", 32'(wr_x), 32'(ex));
    check_eq("wr_y", 32'(wr_y), 32'(ey));
    check_eq("score_pulse", 32'(score_pulse), 32'(ep));
    @(negedge Clk);
  endtask

  task automatic manual_pass(input int x0, input int x1, input int x2, input int x3,
                             input int y0, input int p1);
    int lat;
    pulse_tick();
    wait_write(0, x0, y0, 0, lat);
    wait_write(1, x1, 64, p1, lat);
    wait_write(2, x2, 64, 0, lat);
    wait_write(3, x3, 64, 0, lat);
    check_eq("busy_after_pass", 32'(busy), 32'd0);
    mx[0] = x0; mx[1] = x1; mx[2] = x2; mx[3] = x3; my[0] = y0;
  endtask

  task automatic do_pass(input bit stall);
    int ex [4];
    int ey [4];
    int ep [4];
    int lat;
    int n;
    for (int i = 0; i < 4; i++) begin
      if (mx[i] < 2) begin
        ex[i] = mx[i] + 640 - 2;
        ey[i] = 64 + int'(mlfsr[7:0]);
        ep[i] = 0;
        mlfsr = mlfsr[0] ? ((mlfsr >> 1) ^ 16'hB400) : (mlfsr >> 1);
      end else begin
        ex[i] = mx[i] - 2;
        ey[i] = my[i];
        ep[i] = (mx[i] >= 200 && ex[i] < 200) ? 1 : 0;
      end
      mx[i] = ex[i];
      my[i] = ey[i];
    end
    if (stall) wr_ready = 1'b0;
    pulse_tick();
    if (stall) begin
      n = 0;
      while (!wr_valid && n < 20) begin
        @(negedge Clk);
        n++;
      end
      for (int j = 0; j < 10; j++) begin
        check_eq("stall_valid", 32'(wr_valid), 32'd1);
        check_eq("stall_idx", 32'(wr_idx), 32'd0);
        check_eq("stall_x", 32'(wr_x), 32'(ex[0]));
        check_eq("stall_y", 32'(wr_y), 32'(ey[0]));
        tick = (j == 3);
        @(negedge Clk);
      end
      tick = 1'b0;
      wr_ready = 1'b1;
    end
    for (int i = 0; i < 4; i++) wait_write(i, ex[i], ey[i], ep[i], lat);
    check_eq("busy_after_pass", 32'(busy), 32'd0);
  endtask

  task automatic check_init();
    int lat;
    for (int i = 0; i < 4; i++) wait_write(i, (i + 1) * 160, 64, 0, lat);
    check_eq("init_busy_done", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      mx[i] = (i + 1) * 160;
      my[i] = 64;
    end
  endtask

  initial begin
    int lat;
    int n;
    #2 Reset_n = 1'b0;
    #1;
    check_eq("rst_busy", 32'(busy), 32'd1);
    check_eq("rst_valid", 32'(wr_valid), 32'd0);
    check_eq("rst_x", 32'(wr_x), 32'd0);
    check_eq("rst_pulse", 32'(score_pulse), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    check_init();

    // Tick 1: latency and first scroll step
    pulse_tick();
    wait_write(0, 158, 64, 0, lat);
    check_eq("tick_latency", 32'(lat), 32'd1);
    wait_write(1, 318, 64, 0, lat);
    wait_write(2, 478, 64, 0, lat);
    wait_write(3, 638, 64, 0, lat);
    mx[0] = 158; mx[1] = 318; mx[2] = 478; mx[3] = 638;

    for (int t = 2; t <= 59; t++) do_pass(1'b0);
    check_eq("pulses_before_bird", 32'(pulse_total), 32'd0);
    manual_pass(40, 200, 360, 520, 64, 0);
    manual_pass(38, 198, 358, 518, 64, 1);
    check_eq("pulse_count_61", 32'(pulse_total), 32'd1);
    for (int t = 62; t <= 80; t++) do_pass(1'b0);
    // Entry 0 sits at X=0 and respawns from the seed LFSR byte
    manual_pass(638, 158, 318, 478, 289, 0);
    mlfsr = 16'hE270;
    my[0] = 289;

    // Tick under freeze: no pass, no overrun
    freeze = 1'b1;
    pulse_tick();
    for (int j = 0; j < 5; j++) begin
      check_eq("freeze_busy", 32'(busy), 32'd0);
      check_eq("freeze_valid", 32'(wr_valid), 32'd0);
      @(negedge Clk);
    end
    check_eq("freeze_overrun", 32'(overrun), 32'd0);
    freeze = 1'b0;

    do_pass(1'b1);
    check_eq("overrun_set", 32'(overrun), 32'd1);
    check_eq("pulse_total", 32'(pulse_total), 32'd1);

    // Asynchronous reset while a write is pending
    wr_ready = 1'b0;
    pulse_tick();
    n = 0;
    while (!wr_valid && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check_eq("pre_reset_valid", 32'(wr_valid), 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    check_eq("async_valid", 32'(wr_valid), 32'd0);
    check_eq("async_busy", 32'(busy), 32'd1);
    check_eq("async_overrun", 32'(overrun), 32'd0);
    check_eq("async_idx", 32'(wr_idx), 32'd0);
    wr_ready = 1'b1;
    @(negedge Clk);
    @(negedge Clk) Reset_n = 1'b1;
    check_init();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
